// File: rtl/id_ctrl_pkg.sv
// Shared pipeline defines: opcode/funct constants and next-PC select encodings,
// also used by the fetch unit.
package id_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_JR = 6'b001000;

    typedef enum logic [1:0] {
        PC_ADD4 = 2'b00,
        PC_NPC  = 2'b01,
        PC_RFV1 = 2'b10
    } pcsel_e;

    function automatic logic is_jr(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_RTYPE) && (funct == FUNCT_JR);
    endfunction

endpackage

// File: rtl/id_ctrl_if.sv
// Decode-stage bus: fetch/forwarding inputs and IF/ID, branch and stall outputs.
interface id_ctrl_if;

    logic [31:0] instrF;
    logic [31:0] PC8F;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        ex_load;
    logic        ex_regwrite;
    logic [4:0]  ex_wr_reg;
    logic        mem_load;
    logic [4:0]  mem_wr_reg;

    logic [31:0] instrD;
    logic [31:0] PC8D;
    logic [1:0]  PCsel;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] PCtempD;
    logic        beq;
    logic        CO;
    logic        stall;
    logic [15:0] stall_cnt;

    modport master (
        output instrF, PC8F, rs_val, rt_val, ex_load, ex_regwrite, ex_wr_reg,
               mem_load, mem_wr_reg,
        input  instrD, PC8D, PCsel, i16, i26, PCtempD, beq, CO, stall, stall_cnt
    );

    modport slave (
        input  instrF, PC8F, rs_val, rt_val, ex_load, ex_regwrite, ex_wr_reg,
               mem_load, mem_wr_reg,
        output instrD, PC8D, PCsel, i16, i26, PCtempD, beq, CO, stall, stall_cnt
    );

endinterface

// File: rtl/id_ctrl_hazard_unit.sv
// Stall detection for the instruction held in IF/ID: load-use, branch-after-ALU
// and branch-after-load.
module hazard_unit
    import id_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    input  logic       i_ex_load,
    input  logic       i_ex_regwrite,
    input  logic [4:0] i_ex_wr_reg,
    input  logic       i_mem_load,
    input  logic [4:0] i_mem_wr_reg,
    output logic       o_stall
);

    logic w_uses_rs;
    logic w_uses_rt;
    logic w_needs_early;
    logic w_ex_hit;
    logic w_mem_hit;

    always_comb begin
        w_uses_rs     = 1'b0;
        w_uses_rt     = 1'b0;
        w_needs_early = 1'b0;
        unique case (i_op)
            OP_RTYPE: begin
                w_uses_rs     = 1'b1;
                w_uses_rt     = 1'b1;
                w_needs_early = is_jr(i_op, i_funct);
            end
            OP_BEQ: begin
                w_uses_rs     = 1'b1;
                w_uses_rt     = 1'b1;
                w_needs_early = 1'b1;
            end
            OP_ORI, OP_ADDIU, OP_LW: w_uses_rs = 1'b1;
            OP_SW: begin
                w_uses_rs = 1'b1;
                w_uses_rt = 1'b1;
            end
            default: ;
        endcase
    end

    // $0 is hardwired, so a zero destination never matches.
    assign w_ex_hit  = (i_ex_wr_reg != 5'd0) &&
                       ((w_uses_rs && (i_ex_wr_reg == i_rs)) ||
                        (w_uses_rt && (i_ex_wr_reg == i_rt)));
    assign w_mem_hit = (i_mem_wr_reg != 5'd0) &&
                       ((w_uses_rs && (i_mem_wr_reg == i_rs)) ||
                        (w_uses_rt && (i_mem_wr_reg == i_rt)));

    assign o_stall = (i_ex_load && w_ex_hit) ||
                     (w_needs_early && i_ex_regwrite && w_ex_hit) ||
                     (w_needs_early && i_mem_load && w_mem_hit);

endmodule

// File: rtl/id_ctrl.sv
// Decode-stage control: IF/ID register, branch/jump decode for fetch,
// hazard stall and a saturating stall counter.
module id_ctrl
    import id_ctrl_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    id_ctrl_if.slave bus
);

    logic [31:0] r_instrD;
    logic [31:0] r_PC8D;
    logic [15:0] r_stall_cnt;
    logic        w_stall;
    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    pcsel_e      w_pcsel;

    assign w_op    = r_instrD[31:26];
    assign w_funct = r_instrD[5:0];

    hazard_unit u_hazard (
        .i_op          (w_op),
        .i_funct       (w_funct),
        .i_rs          (r_instrD[25:21]),
        .i_rt          (r_instrD[20:16]),
        .i_ex_load     (bus.ex_load),
        .i_ex_regwrite (bus.ex_regwrite),
        .i_ex_wr_reg   (bus.ex_wr_reg),
        .i_mem_load    (bus.mem_load),
        .i_mem_wr_reg  (bus.mem_wr_reg),
        .o_stall       (w_stall)
    );

    // No flush on taken branch/jump: the delay slot always executes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instrD <= '0;
            r_PC8D   <= '0;
        end else if (!w_stall) begin
            r_instrD <= bus.instrF;
            r_PC8D   <= bus.PC8F;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    always_comb begin
        w_pcsel = PC_ADD4;
        if ((w_op == OP_BEQ) || (w_op == OP_J) || (w_op == OP_JAL))
            w_pcsel = PC_NPC;
        else if (is_jr(w_op, w_funct))
            w_pcsel = PC_RFV1;
    end

    assign bus.instrD    = r_instrD;
    assign bus.PC8D      = r_PC8D;
    assign bus.PCsel     = w_pcsel;
    assign bus.i16       = r_instrD[15:0];
    assign bus.i26       = r_instrD[25:0];
    assign bus.PCtempD   = bus.rs_val;
    assign bus.beq       = (w_op == OP_BEQ);
    assign bus.CO        = (bus.rs_val == bus.rt_val);
    assign bus.stall     = w_stall;
    assign bus.stall_cnt = r_stall_cnt;

endmodule
